// File: rtl/perceptron_pkg.sv
// Shared opcodes, response codes and controller state encoding for the perceptron UART sequencer.
package perceptron_pkg;

    localparam logic [7:0] OP_WR_W = 8'h01;
    localparam logic [7:0] OP_WR_X = 8'h02;
    localparam logic [7:0] OP_RUN  = 8'h03;
    localparam logic [7:0] OP_RD_W = 8'h04;

    localparam logic [7:0] RSP_ACK = 8'hA5;
    localparam logic [7:0] RSP_ERR = 8'hEE;
    localparam logic [7:0] RSP_TMO = 8'hEF;

    // Encoding doubles as the LED state code.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARG0     = 3'd1,
        ST_ARG1     = 3'd2,
        ST_EXEC     = 3'd3,
        ST_READ     = 3'd4,
        ST_RUN_WAIT = 3'd5,
        ST_TX_SEND  = 3'd6
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_EXEC) || (s == ST_READ) || (s == ST_RUN_WAIT) || (s == ST_TX_SEND);
    endfunction

endpackage

// File: rtl/perceptron_ctrl_timer.sv
// Loadable down-counter; tc flags the last counted cycle (count == 1).
module ctrl_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign tc = (count_q == W'(1));

endmodule

// File: rtl/perceptron_ctrl.sv
// UART command sequencer: parses host frames, drives the perceptron register file and
// compute core, and returns ack/result/error bytes to the transmitter.
//
//   state    | meaning
//   IDLE     | waiting for an opcode byte
//   ARG0     | waiting for the index byte
//   ARG1     | waiting for the value byte
//   EXEC     | one-cycle write strobe or start pulse
//   READ     | wr_idx held, rd_data captured for reply
//   RUN_WAIT | waiting for done or run timeout
//   TX_SEND  | reply byte offered until tx_ready
module perceptron_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS     = 8,
    parameter int IDX_W        = 3,
    parameter int RUN_TIMEOUT  = 1024,
    parameter int BYTE_TIMEOUT = 500000
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             wr_en,
    output logic             wr_sel,
    output logic [IDX_W-1:0] wr_idx,
    output logic [7:0]       wr_data,
    input  logic [7:0]       rd_data,
    output logic             start,
    input  logic             done,
    input  logic [7:0]       result,
    output logic             busy,
    output logic [7:0]       leds
);
    localparam int RUN_W  = $clog2(RUN_TIMEOUT + 1);
    localparam int BYTE_W = $clog2(BYTE_TIMEOUT + 1);
    // Run timer is loaded in EXEC, so one less keeps the reply exactly RUN_TIMEOUT after start.
    localparam logic [RUN_W-1:0]  RUN_LOAD  = RUN_W'(RUN_TIMEOUT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LOAD = BYTE_W'(BYTE_TIMEOUT);
    localparam logic [7:0]        IDX_LIMIT = 8'(N_INPUTS);

    state_t           state_q, state_d;
    logic [7:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       val_q;
    logic [7:0]       tx_q;
    logic [3:0]       last_res_q;
    logic             ovr_q;

    logic       latch_op, latch_idx, latch_val;
    logic       tx_load, res_load, ovr_set;
    logic [7:0] tx_byte;
    logic       byte_load, run_load;
    logic       byte_tc, run_tc;
    logic       in_arg, in_run;

    assign in_arg = (state_q == ST_ARG0) || (state_q == ST_ARG1);
    assign in_run = (state_q == ST_RUN_WAIT);

    ctrl_timer #(.W(BYTE_W)) u_byte_timer (
        .clk      (clk),
        .nRst     (nRst),
        .load     (byte_load),
        .load_val (BYTE_LOAD),
        .en       (in_arg),
        .tc       (byte_tc)
    );

    ctrl_timer #(.W(RUN_W)) u_run_timer (
        .clk      (clk),
        .nRst     (nRst),
        .load     (run_load),
        .load_val (RUN_LOAD),
        .en       (in_run),
        .tc       (run_tc)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        start     = 1'b0;
        latch_op  = 1'b0;
        latch_idx = 1'b0;
        latch_val = 1'b0;
        tx_load   = 1'b0;
        tx_byte   = 8'h00;
        res_load  = 1'b0;
        ovr_set   = 1'b0;
        byte_load = 1'b0;
        run_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    latch_op  = 1'b1;
                    byte_load = 1'b1;
                    case (rx_data)
                        OP_WR_W, OP_WR_X, OP_RD_W: state_d = ST_ARG0;
                        OP_RUN:                    state_d = ST_EXEC;
                        default: begin
                            tx_load = 1'b1;
                            tx_byte = RSP_ERR;
                            state_d = ST_TX_SEND;
                        end
                    endcase
                end
            end
            ST_ARG0: begin
                if (rx_valid) begin
                    latch_idx = 1'b1;
                    byte_load = 1'b1;
                    if (rx_data >= IDX_LIMIT) begin
                        tx_load = 1'b1;
                        tx_byte = RSP_ERR;
                        state_d = ST_TX_SEND;
                    end else if (op_q == OP_RD_W) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_ARG1;
                    end
                end else if (byte_tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARG1: begin
                if (rx_valid) begin
                    latch_val = 1'b1;
                    state_d   = ST_EXEC;
                end else if (byte_tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_RUN) begin
                    start    = 1'b1;
                    run_load = 1'b1;
                    state_d  = ST_RUN_WAIT;
                end else begin
                    wr_en   = 1'b1;
                    tx_load = 1'b1;
                    tx_byte = RSP_ACK;
                    state_d = ST_TX_SEND;
                end
            end
            ST_READ: begin
                tx_load = 1'b1;
                tx_byte = rd_data;
                state_d = ST_TX_SEND;
            end
            ST_RUN_WAIT: begin
                if (done) begin
                    tx_load  = 1'b1;
                    tx_byte  = result;
                    res_load = 1'b1;
                    state_d  = ST_TX_SEND;
                end else if (run_tc) begin
                    tx_load = 1'b1;
                    tx_byte = RSP_TMO;
                    state_d = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_valid && is_busy(state_q)) begin
            ovr_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            op_q       <= 8'h00;
            idx_q      <= '0;
            val_q      <= 8'h00;
            tx_q       <= 8'h00;
            last_res_q <= 4'h0;
            ovr_q      <= 1'b0;
        end else begin
            if (latch_op)  op_q       <= rx_data;
            if (latch_idx) idx_q      <= rx_data[IDX_W-1:0];
            if (latch_val) val_q      <= rx_data;
            if (tx_load)   tx_q       <= tx_byte;
            if (res_load)  last_res_q <= result[3:0];
            if (ovr_set)   ovr_q      <= 1'b1;
        end
    end

    assign tx_valid = (state_q == ST_TX_SEND);
    assign tx_data  = tx_q;
    assign wr_sel   = (op_q == OP_WR_X);
    assign wr_idx   = idx_q;
    assign wr_data  = val_q;
    assign busy     = is_busy(state_q);
    assign leds     = {state_q, ovr_q, last_res_q};

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Directed and randomized frame-level checks of perceptron_ctrl against a frame-rule reference model.
module tb_perceptron_ctrl;

    localparam int NI = 8;
    localparam int IW = 3;
    localparam int RT = 64;
    localparam int BT = 100;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic          wr_en;
    logic          wr_sel;
    logic [IW-1:0] wr_idx;
    logic [7:0]    wr_data;
    logic [7:0]    rd_data;
    logic          start;
    logic          done = 1'b0;
    logic [7:0]    result = 8'h00;
    logic          busy;
    logic [7:0]    leds;

    perceptron_ctrl #(
        .N_INPUTS(NI), .IDX_W(IW), .RUN_TIMEOUT(RT), .BYTE_TIMEOUT(BT)
    ) dut (
        .clk(clk), .nRst(nRst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_data(rd_data), .start(start), .done(done), .result(result),
        .busy(busy), .leds(leds)
    );

    always #5 clk = ~clk;

    // Environment: weight register file (preload + DUT writes) and output loggers.
    logic [7:0] pre_w [NI];
    logic [7:0] rf_w  [NI];
    bit         rf_v  [NI];
    logic [7:0] tx_buf [256];
    int         tx_wr = 0;
    int         cyc_n = 0;
    int         wr_cnt = 0;
    int         start_cnt = 0;
    int         start_cyc = 0;
    int         tx_cyc = 0;

    assign rd_data = rf_v[wr_idx] ? rf_w[wr_idx] : pre_w[wr_idx];

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (!wr_sel) begin
                rf_w[wr_idx] <= wr_data;
                rf_v[wr_idx] <= 1'b1;
            end
        end
        if (start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc_n;
        end
        if (tx_valid && tx_ready) begin
            tx_buf[tx_wr & 255] <= tx_data;
            tx_wr  <= tx_wr + 1;
            tx_cyc <= cyc_n;
        end
    end

    int         checks = 0;
    int         failures = 0;
    int         tx_rd = 0;
    logic [7:0] exp_w [NI];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp, input int budget);
        int n = 0;
        while (tx_wr == tx_rd && n < budget) begin
            cyc();
            n++;
        end
        check({tag, "_count"}, 32'(tx_wr - tx_rd), 32'd1);
        if (tx_wr != tx_rd) begin
            check(tag, 32'(tx_buf[tx_rd & 255]), 32'(exp));
            tx_rd++;
        end
    endtask

    task automatic do_write(input string tag, input logic [7:0] op, input int idx, input logic [7:0] val);
        int w0 = wr_cnt;
        send_byte(op);
        send_byte(8'(idx));
        send_byte(val);
        if (op == 8'h01) exp_w[idx] = val;
        wait_tx(tag, 8'hA5, 20);
        check({tag, "_wrcnt"}, 32'(wr_cnt - w0), 32'd1);
    endtask

    task automatic do_run(input string tag, input int delay, input logic [7:0] res);
        int s0 = start_cnt;
        send_byte(8'h03);
        repeat (delay) cyc();
        done   = 1'b1;
        result = res;
        cyc();
        done = 1'b0;
        wait_tx(tag, res, 20);
        check({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
        check({tag, "_led_res"}, 32'(leds[3:0]), 32'(res[3:0]));
    endtask

    initial begin
        int w0, t0, s0, kind, idx, d;
        logic [7:0] v, d0;
        bit stable;

        for (int i = 0; i < NI; i++) begin
            pre_w[i] = 8'($urandom);
            exp_w[i] = pre_w[i];
        end

        // Reset state
        #12;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_wr_idx_data", 32'({wr_sel, wr_idx, wr_data}), 32'd0);
        cyc();
        nRst = 1'b1;
        cyc();

        // Weight write with exact strobe/ack timing
        w0 = wr_cnt;
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h7F);
        exp_w[3] = 8'h7F;
        check("wr_en_strobe", 32'(wr_en), 32'd1);
        check("wr_fields", 32'({wr_sel, wr_idx, wr_data}), 32'({1'b0, 3'd3, 8'h7F}));
        check("wr_busy", 32'(busy), 32'd1);
        cyc();
        check("wr_en_single", 32'(wr_en), 32'd0);
        check("ack_valid", 32'(tx_valid), 32'd1);
        check("ack_data", 32'(tx_data), 32'hA5);
        wait_tx("ack_byte", 8'hA5, 10);
        check("wr_count", 32'(wr_cnt - w0), 32'd1);

        // Out-of-range index; trailing byte lands on the TX accept cycle and is dropped
        w0 = wr_cnt;
        send_byte(8'h02);
        send_byte(8'h08);
        send_byte(8'h10);
        wait_tx("bad_idx", 8'hEE, 10);
        check("bad_idx_nowrite", 32'(wr_cnt - w0), 32'd0);
        check("overrun_led", 32'(leds[4]), 32'd1);
        do_write("after_bad", 8'h02, 5, 8'h3C);

        // Run with done after 20 cycles
        send_byte(8'h03);
        check("run_start", 32'(start), 32'd1);
        check("run_busy", 32'(busy), 32'd1);
        repeat (20) cyc();
        check("run_wait_led", 32'(leds[7:5]), 32'd5);
        done = 1'b1; result = 8'h01;
        cyc();
        done = 1'b0;
        wait_tx("run_res", 8'h01, 10);
        check("run_led_res", 32'(leds[3:0]), 32'd1);

        // done on the last allowed cycle beats the timeout
        do_run("run_edge", RT - 1, 8'h5A);

        // Run timeout
        s0 = start_cnt;
        send_byte(8'h03);
        wait_tx("run_tmo", 8'hEF, RT + 20);
        check("tmo_latency", 32'(tx_cyc - start_cyc), 32'(RT));
        check("tmo_starts", 32'(start_cnt - s0), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_keeps_res", 32'(leds[3:0]), 32'hA);

        // Stray done in IDLE is ignored
        t0 = tx_wr;
        done = 1'b1;
        cyc();
        done = 1'b0;
        repeat (5) cyc();
        check("stray_done", 32'(tx_wr - t0), 32'd0);

        // Inter-byte timeout discards partial frame
        w0 = wr_cnt;
        t0 = tx_wr;
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (BT + 5) cyc();
        check("bto_nowrite", 32'(wr_cnt - w0), 32'd0);
        check("bto_notx", 32'(tx_wr - t0), 32'd0);
        check("bto_idle", 32'(leds[7:5]), 32'd0);
        send_byte(8'h04);
        send_byte(8'h02);
        wait_tx("read_w2", exp_w[2], 10);

        // Gap of exactly BT cycles is still accepted; one more is not
        send_byte(8'h04);
        repeat (BT - 1) cyc();
        send_byte(8'h03);
        wait_tx("gap_ok", exp_w[3], 10);
        send_byte(8'h04);
        repeat (BT) cyc();
        send_byte(8'h05);
        wait_tx("gap_late", 8'hEE, 10);

        // Randomized frames against the reference model
        for (int n = 0; n < 12; n++) begin
            kind = int'($urandom_range(0, 4));
            idx  = int'($urandom_range(0, NI - 1));
            v    = 8'($urandom);
            case (kind)
                0: do_write("rnd_wr_w", 8'h01, idx, v);
                1: do_write("rnd_wr_x", 8'h02, idx, v);
                2: begin
                    send_byte(8'h04);
                    send_byte(8'(idx));
                    wait_tx("rnd_read", exp_w[idx], 10);
                end
                3: begin
                    d = int'($urandom_range(1, RT - 1));
                    do_run("rnd_run", d, v);
                end
                default: begin
                    w0 = wr_cnt;
                    send_byte(8'(1 + 3 * int'($urandom_range(0, 1))));
                    send_byte(8'($urandom_range(NI, 255)));
                    wait_tx("rnd_bad_idx", 8'hEE, 10);
                    check("rnd_bad_nowr", 32'(wr_cnt - w0), 32'd0);
                end
            endcase
            repeat ($urandom_range(0, 5)) cyc();
        end
        send_byte(8'(5 + $urandom_range(0, 200)));
        wait_tx("rnd_bad_op", 8'hEE, 10);

        // Back-pressure with overrun, then reset mid-TX_SEND
        nRst = 1'b0;
        cyc();
        nRst = 1'b1;
        cyc();
        check("rst2_leds", 32'(leds), 32'd0);
        tx_ready = 1'b0;
        send_byte(8'h04);
        send_byte(8'h05);
        cyc();
        d0 = tx_data;
        check("hold_data", 32'(d0), 32'(exp_w[5]));
        stable = 1'b1;
        t0 = tx_wr;
        for (int k = 0; k < 50; k++) begin
            rx_valid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            cyc();
            if (tx_data !== d0 || tx_valid !== 1'b1) stable = 1'b0;
        end
        rx_valid = 1'b0;
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_overrun", 32'(leds[4]), 32'd1);
        check("hold_state", 32'(leds[7:5]), 32'd6);
        #2;
        nRst = 1'b0;
        #1;
        check("rst_mid_txv", 32'(tx_valid), 32'd0);
        check("rst_mid_leds", 32'(leds), 32'd0);
        tx_ready = 1'b1;
        cyc();
        nRst = 1'b1;
        repeat (3) cyc();
        check("rst_mid_notx", 32'(tx_wr - t0), 32'd0);
        do_write("post_rst", 8'h01, 0, 8'h81);

        repeat (5) cyc();
        check("no_extra_tx", 32'(tx_wr - tx_rd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perceptron_ctrl.md
Name: perceptron_ctrl

Overview:
- UART command sequencer between the host byte stream and the perceptron datapath on the Mojo board.
- Parses host command frames to load weights and inputs, triggers an evaluation, and returns results or error codes as bytes to the UART transmitter.
- Drives the 8 board LEDs with controller status.
- Sits between the UART RX/TX byte interfaces and the perceptron weight/input register file and compute core.

Parameters:
- N_INPUTS, 8, number of weight/input slots; valid index range 0..N_INPUTS-1.
- IDX_W, 3, index field width; must satisfy 2^IDX_W >= N_INPUTS.
- RUN_TIMEOUT, 1024, clk cycles allowed between start and done.
- BYTE_TIMEOUT, 500000, idle clk cycles allowed between bytes of one frame (10 ms at 50 MHz).

Ports:
- clk  in  1  50 MHz system clock.
- nRst  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse; rx_data holds a received byte.
- rx_data  in  8  received host byte.
- tx_valid  out  1  byte offered to the UART transmitter.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- wr_en  out  1  one-cycle register-file write strobe.
- wr_sel  out  1  0 = weight bank, 1 = input bank.
- wr_idx  out  IDX_W  write/read slot index.
- wr_data  out  8  signed write value.
- rd_data  in  8  weight[wr_idx], valid 1 cycle after wr_idx is stable.
- start  out  1  one-cycle evaluation trigger.
- done  in  1  one-cycle pulse; result is valid.
- result  in  8  perceptron output byte.
- busy  out  1  high outside IDLE/ARG states.
- leds  out  8  status display.

Behaviour:
- Reset: all outputs 0, state IDLE, overrun flag 0, last-result register 0, timers 0.
- Frames (byte order):
  - 0x01 idx val: write weight.
  - 0x02 idx val: write input.
  - 0x03: run.
  - 0x04 idx: read weight.
  - Any other opcode in IDLE: respond 0xEE, return to IDLE.
- States and transitions:
  - IDLE: on rx_valid, latch the opcode.
    - 0x01/0x02/0x04 -> ARG0.
    - 0x03 -> EXEC.
    - Unknown -> TX_SEND with 0xEE.
  - ARG0: on rx_valid, latch idx.
    - idx >= N_INPUTS -> TX_SEND with 0xEE.
    - Opcode 0x04 -> READ.
    - Otherwise -> ARG1.
  - ARG1: on rx_valid, latch val -> EXEC.
  - EXEC (one cycle):
    - Write ops: wr_en=1 with wr_sel/wr_idx/wr_data, then TX_SEND with ack 0xA5.
    - Run op: start=1 -> RUN_WAIT.
  - READ: hold wr_idx for one cycle, capture rd_data into tx_data -> TX_SEND.
  - RUN_WAIT: count cycles from 0.
    - done before the count reaches RUN_TIMEOUT: latch result into last-result register and tx_data -> TX_SEND.
    - Count reaches RUN_TIMEOUT: tx_data=0xEF -> TX_SEND.
    - done and timeout in the same cycle: done wins.
  - TX_SEND: hold tx_valid=1 and tx_data stable until tx_ready; on accept, drop tx_valid next cycle -> IDLE.
- Timing: write latency, last frame byte to wr_en, is 1 cycle; ack appears on tx_valid the cycle after wr_en.
- Inter-byte timeout: in ARG0/ARG1 the idle counter resets on each rx_valid. When it reaches BYTE_TIMEOUT, the partial frame is discarded silently -> IDLE, no tx.
- Overrun: rx_valid while in EXEC/READ/RUN_WAIT/TX_SEND drops the byte and sets the sticky overrun flag; only reset clears it. rx_valid in the same cycle as the TX_SEND accept is also dropped.
- An unused done pulse outside RUN_WAIT is ignored.
- busy=1 in EXEC, READ, RUN_WAIT, TX_SEND.
- leds: {state code [2:0], overrun, last result [3:0]}.
  - State codes: IDLE=0, ARG0=1, ARG1=2, EXEC=3, READ=4, RUN_WAIT=5, TX_SEND=6.
- Reset mid-frame or mid-run: immediate return to IDLE, all strobes low, no tx.

Decomposition:
- Shared package perceptron_pkg holds:
  - opcode constants OP_WR_W=0x01, OP_WR_X=0x02, OP_RUN=0x03, OP_RD_W=0x04;
  - response constants RSP_ACK=0xA5, RSP_ERR=0xEE, RSP_TMO=0xEF;
  - the state enum.
- One sub-module: ctrl_timer, a loadable/clearable down-counter with terminal-count flag, instanced twice (byte timeout, run timeout).

Test Plan:
- Frame 0x01,0x03,0x7F -> one-cycle wr_en with wr_sel=0, wr_idx=3, wr_data=0x7F; then tx byte 0xA5.
- Frame 0x02,0x08,0x10 with N_INPUTS=8 -> no wr_en; tx 0xEE; next frame is accepted normally.
- Frame 0x03, done pulse with result=0x01 after 20 cycles -> single start pulse; tx 0x01; leds[3:0]=1.
- Frame 0x03, done never asserted -> tx 0xEF exactly RUN_TIMEOUT cycles after start; busy low afterwards.
- Send 0x01,0x02, then idle BYTE_TIMEOUT cycles, then 0x04,0x02 -> no write, no tx for the partial frame; read returns the weight[2] value preloaded via rd_data model.
- Hold tx_ready=0 for 50 cycles while injecting rx bytes -> tx_data stable, leds[4]=1; assert nRst low mid-TX_SEND -> tx_valid=0 and leds=0x00 immediately.
